// File: rtl/key_debounce_if.sv
// Key pin and debounced event signals between a pushbutton reader and its consumer.
interface key_debounce_if;
    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_click;
    logic key_long;

    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_click,
        input  key_long
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_click,
        output key_long
    );
endinterface

// File: rtl/key_debounce.sv
// Debounced pushbutton reader: synchronises a bouncing key pin and emits a clean
// pressed level plus single-cycle press, release, click and long-press pulses.
module key_debounce #(
    parameter logic [31:0] DEBOUNCE_CNT = 32'd1000000,
    parameter logic [31:0] LONG_CNT     = 32'd50000000,
    parameter logic        ACTIVE_LOW   = 1'b1
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    key_debounce_if.slave kif
);
    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 32'd1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        LONG_HELD,
        RELEASE_DB
    } state_t;

    state_t           state, state_d;
    logic             sync0, sync1, k_s;
    logic [CNT_W-1:0] db_cnt, db_cnt_d;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
    logic             long_flag, long_flag_d;
    logic             level_d, press_d, release_d, click_d, long_d;
    logic             level_q, press_q, release_q, click_q, long_q;

    // Two-flop synchroniser, reset to the released pin level so reset never looks like a press
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync0 <= ACTIVE_LOW;
            sync1 <= ACTIVE_LOW;
        end else begin
            sync0 <= kif.key_in;
            sync1 <= sync0;
        end
    end

    assign k_s = sync1 ^ ACTIVE_LOW;

    // State, counters and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            long_flag <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state     <= state_d;
            db_cnt    <= db_cnt_d;
            hold_cnt  <= hold_cnt_d;
            long_flag <= long_flag_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
        end
    end

    // Next state, counter updates and next output values
    always_comb begin
        state_d     = state;
        db_cnt_d    = db_cnt;
        hold_cnt_d  = hold_cnt;
        long_flag_d = long_flag;
        press_d     = 1'b0;
        release_d   = 1'b0;
        click_d     = 1'b0;
        long_d      = 1'b0;

        case (state)
            IDLE: begin
                if (k_s) begin
                    state_d     = PRESS_DB;
                    db_cnt_d    = '0;
                    long_flag_d = 1'b0;
                end
            end
            PRESS_DB: begin
                if (!k_s) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_d    = HELD;
                    hold_cnt_d = '0;
                    press_d    = 1'b1;
                end else begin
                    db_cnt_d = db_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!k_s) begin
                    state_d  = RELEASE_DB;
                    db_cnt_d = '0;
                end else if (hold_cnt == LONG_LAST) begin
                    state_d     = LONG_HELD;
                    long_d      = 1'b1;
                    long_flag_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                if (!k_s) begin
                    state_d  = RELEASE_DB;
                    db_cnt_d = '0;
                end
            end
            RELEASE_DB: begin
                // A bounce back to pressed resumes the hold with hold_cnt untouched
                if (k_s) begin
                    state_d = long_flag ? LONG_HELD : HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    click_d   = !long_flag;
                end else begin
                    db_cnt_d = db_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        level_d = (state_d == HELD) || (state_d == LONG_HELD) || (state_d == RELEASE_DB);
    end

    assign kif.key_level   = level_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.key_click   = click_q;
    assign kif.key_long    = long_q;
endmodule
